// File: rtl/free_list_pkg.sv
// Shared types and sizes for the physical-register free list.
// Pointer arithmetic wraps modulo DEPTH, which is not a power of two.
package free_list_pkg;

  localparam int NUM_PREG = 128;
  localparam int NUM_AREG = 32;
  localparam int WAYS     = 4;
  localparam int PREG_W   = 7;
  localparam int DEPTH    = NUM_PREG - NUM_AREG;

  typedef logic [PREG_W-1:0] preg_idx_t;
  typedef logic [6:0]        ptr_t;
  typedef logic [2:0]        lane_cnt_t;

  function automatic ptr_t ptr_add(ptr_t p, lane_cnt_t d);
    logic [7:0] s;
    s = {1'b0, p} + {5'b0, d};
    if (s >= 8'(DEPTH)) s = s - 8'(DEPTH);
    return s[6:0];
  endfunction

endpackage

// File: rtl/free_list_compact.sv
// Prefix popcount: per-lane offset among the set lanes, plus the total.
// Used to compact both allocation reads and commit writes.
module fl_compact
  import free_list_pkg::*;
(
  input  logic [WAYS-1:0]            vec,
  output lane_cnt_t [WAYS-1:0]       offset,
  output lane_cnt_t                  total
);

  always_comb begin
    lane_cnt_t acc;
    acc = '0;
    for (int i = 0; i < WAYS; i++) begin
      offset[i] = acc;
      acc = acc + lane_cnt_t'(vec[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical registers for the 4-wide rename stage.
// Speculative head, committed arch_head, and tail for returned pregs.
module free_list
  import free_list_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WAYS-1:0]              alloc_req_vec,
  input  logic                         alloc_en,
  output logic                         alloc_ready,
  output logic [WAYS-1:0][PREG_W-1:0]  alloc_preg_vec,
  input  logic [WAYS-1:0]              commit_valid_vec,
  input  logic [WAYS-1:0][PREG_W-1:0]  commit_free_preg_vec,
  input  logic                         recover_valid,
  output logic [6:0]                   free_count
);

  preg_idx_t fl [DEPTH];

  ptr_t       head;
  ptr_t       arch_head;
  ptr_t       tail;
  logic [6:0] count;
  logic [6:0] count_nxt;

  lane_cnt_t [WAYS-1:0] a_off;
  lane_cnt_t [WAYS-1:0] f_off;
  lane_cnt_t            n_alloc;
  lane_cnt_t            n_free;
  logic                 fire;

  fl_compact u_alloc (
    .vec    (alloc_req_vec),
    .offset (a_off),
    .total  (n_alloc)
  );

  fl_compact u_free (
    .vec    (commit_valid_vec),
    .offset (f_off),
    .total  (n_free)
  );

  assign alloc_ready = count >= 7'(n_alloc);
  assign fire        = alloc_en & alloc_ready & ~recover_valid;
  assign free_count  = count;

  always_comb begin
    alloc_preg_vec = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (alloc_req_vec[i])
        alloc_preg_vec[i] = fl[ptr_add(head, a_off[i])];
    end
  end

  always_comb begin
    count_nxt = count + 7'(n_free);
    if (fire) count_nxt = count_nxt - 7'(n_alloc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        fl[k] <= preg_idx_t'(NUM_AREG + k);
      head      <= '0;
      arch_head <= '0;
      tail      <= '0;
      count     <= 7'(DEPTH);
    end else begin
      for (int i = 0; i < WAYS; i++) begin
        if (commit_valid_vec[i])
          fl[ptr_add(tail, f_off[i])] <= commit_free_preg_vec[i];
      end
      tail      <= ptr_add(tail, n_free);
      arch_head <= ptr_add(arch_head, n_free);
      if (recover_valid) begin
        // Architectural free count is always DEPTH.
        head  <= ptr_add(arch_head, n_free);
        count <= 7'(DEPTH);
      end else begin
        if (fire) head <= ptr_add(head, n_alloc);
        count <= count_nxt;
      end
    end
  end

  // Outstanding allocations equal DEPTH - count, so this also bounds commits.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, count} + 8'(n_free)) <= 8'(DEPTH));

  for (genvar g = 0; g < WAYS; g++) begin : g_chk
    a_nonzero_free: assert property (@(posedge clk) disable iff (rst)
      commit_valid_vec[g] |-> (commit_free_preg_vec[g] != '0));
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: vector table plus multi-cycle
// sequences, with expected outputs queued and compared mid-cycle.
module tb_free_list;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       alloc_req_vec;
  logic             alloc_en;
  logic             alloc_ready;
  logic [3:0][6:0]  alloc_preg_vec;
  logic [3:0]       commit_valid_vec;
  logic [3:0][6:0]  commit_free_preg_vec;
  logic             recover_valid;
  logic [6:0]       free_count;

  free_list dut (
    .clk                  (clk),
    .rst                  (rst),
    .alloc_req_vec        (alloc_req_vec),
    .alloc_en             (alloc_en),
    .alloc_ready          (alloc_ready),
    .alloc_preg_vec       (alloc_preg_vec),
    .commit_valid_vec     (commit_valid_vec),
    .commit_free_preg_vec (commit_free_preg_vec),
    .recover_valid        (recover_valid),
    .free_count           (free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            rst;
    logic [3:0]      req;
    logic            en;
    logic [3:0]      cv;
    logic [3:0][6:0] cf;
    logic            rec;
    logic            er;
    logic [3:0][6:0] ep;
    int              ec;
  } vec_t;

  typedef struct {
    string           name;
    logic            ready;
    logic [3:0][6:0] pregs;
    int              cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[8];
  int   n_chk = 0;
  int   n_fail = 0;

  localparam logic [3:0][6:0] P0 = '0;

  function automatic vec_t mkv(string nm, logic r, logic [3:0] req,
                               logic en, logic [3:0] cv,
                               logic [3:0][6:0] cf, logic rec, logic er,
                               logic [3:0][6:0] ep, int ec);
    vec_t v;
    v.name = nm; v.rst = r; v.req = req; v.en = en; v.cv = cv;
    v.cf = cf; v.rec = rec; v.er = er; v.ep = ep; v.ec = ec;
    return v;
  endfunction

  function automatic logic [3:0][6:0] mk(int b);
    logic [3:0][6:0] r;
    for (int j = 0; j < 4; j++) r[j] = 7'(b + j);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    rst                  = v.rst;
    alloc_req_vec        = v.req;
    alloc_en             = v.en;
    commit_valid_vec     = v.cv;
    commit_free_preg_vec = v.cf;
    recover_valid        = v.rec;
    e.name = v.name; e.ready = v.er; e.pregs = v.ep; e.cnt = v.ec;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = sb.pop_front();
      chk({e.name, ".ready"}, 32'(alloc_ready), 32'(e.ready));
      chk({e.name, ".pregs"}, 32'(alloc_preg_vec), 32'(e.pregs));
      chk({e.name, ".count"}, 32'(free_count), 32'(e.cnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    alloc_req_vec = '0; alloc_en = 1'b0;
    commit_valid_vec = '0; commit_free_preg_vec = '0;
    recover_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    tbl[0] = mkv("all4",     0, 4'b1111, 1, 0, P0, 0, 1, mk(32), 96);
    tbl[1] = mkv("cnt92",    0, 4'b0000, 0, 0, P0, 0, 1, P0, 92);
    tbl[2] = mkv("rst_prio", 1, 4'b1010, 1, 0, P0, 0, 1,
                 {7'd37, 7'd0, 7'd36, 7'd0}, 92);
    tbl[3] = mkv("sparse",   0, 4'b1010, 1, 0, P0, 0, 1,
                 {7'd33, 7'd0, 7'd32, 7'd0}, 96);
    tbl[4] = mkv("cnt94",    0, 4'b0000, 0, 0, P0, 0, 1, P0, 94);
    tbl[5] = mkv("no_en",    0, 4'b1111, 0, 0, P0, 0, 1, mk(34), 94);
    tbl[6] = mkv("single",   0, 4'b0001, 1, 0, P0, 0, 1,
                 {7'd0, 7'd0, 7'd0, 7'd34}, 94);
    tbl[7] = mkv("cnt93",    0, 4'b0000, 0, 0, P0, 0, 1, P0, 93);
    for (int i = 0; i < 8; i++) apply(tbl[i]);

    // Starvation: drain to two free entries
    apply(mkv("rst1", 1, 0, 0, 0, P0, 0, 1, P0, 93));
    for (int c = 0; c < 23; c++)
      apply(mkv("drain", 0, 4'b1111, 1, 0, P0, 0, 1,
                mk(32 + 4 * c), 96 - 4 * c));
    apply(mkv("drain2", 0, 4'b0011, 1, 0, P0, 0, 1,
              {7'd0, 7'd0, 7'd125, 7'd124}, 4));
    apply(mkv("starve3", 0, 4'b0111, 1, 0, P0, 0, 0,
              {7'd0, 7'd32, 7'd127, 7'd126}, 2));
    apply(mkv("last2", 0, 4'b0011, 1, 0, P0, 0, 1,
              {7'd0, 7'd0, 7'd127, 7'd126}, 2));
    apply(mkv("empty", 0, 4'b0000, 0, 0, P0, 0, 1, P0, 0));
    apply(mkv("starve1", 0, 4'b0001, 1, 0, P0, 0, 0,
              {7'd0, 7'd0, 7'd0, 7'd32}, 0));

    // Wrap-around reuse of committed pregs
    apply(mkv("commit4", 0, 0, 0, 4'b1111, {7'd8, 7'd7, 7'd6, 7'd5},
              0, 1, P0, 0));
    apply(mkv("wrap_reuse", 0, 4'b1111, 1, 0, P0, 0, 1,
              {7'd8, 7'd7, 7'd6, 7'd5}, 4));
    apply(mkv("free2", 0, 0, 0, 4'b0011, {7'd0, 7'd0, 7'd10, 7'd9},
              0, 1, P0, 0));
    apply(mkv("alloc2_free2", 0, 4'b0011, 1, 4'b0011,
              {7'd0, 7'd0, 7'd12, 7'd11}, 0, 1,
              {7'd0, 7'd0, 7'd10, 7'd9}, 2));
    apply(mkv("balanced", 0, 4'b0011, 0, 0, P0, 0, 1,
              {7'd0, 7'd0, 7'd12, 7'd11}, 2));

    // Recover with a same-cycle commit
    apply(mkv("rst2", 1, 0, 0, 0, P0, 0, 1, P0, 2));
    apply(mkv("rc_a", 0, 4'b1111, 1, 0, P0, 0, 1, mk(32), 96));
    apply(mkv("rc_b", 0, 4'b1111, 1, 0, P0, 0, 1, mk(36), 92));
    apply(mkv("recover", 0, 4'b1111, 1, 4'b0011,
              {7'd0, 7'd0, 7'd4, 7'd3}, 1, 1, mk(40), 88));
    apply(mkv("post_rc", 0, 4'b0001, 1, 0, P0, 0, 1,
              {7'd0, 7'd0, 7'd0, 7'd34}, 96));
    for (int c = 0; c < 23; c++)
      apply(mkv("rc_drain", 0, 4'b1111, 1, 0, P0, 0, 1,
                mk(35 + 4 * c), 95 - 4 * c));
    apply(mkv("rc_tail", 0, 4'b0111, 1, 0, P0, 0, 1,
              {7'd0, 7'd4, 7'd3, 7'd127}, 3));
    apply(mkv("rc_empty", 0, 0, 0, 0, P0, 0, 1, P0, 0));

    // Reset in the middle of traffic
    apply(mkv("rst_mid", 1, 4'b1111, 1, 4'b0001,
              {7'd0, 7'd0, 7'd0, 7'd9}, 0, 0, mk(34), 0));
    apply(mkv("after_rst", 0, 4'b0001, 1, 0, P0, 0, 1,
              {7'd0, 7'd0, 7'd0, 7'd32}, 96));
    apply(mkv("after_rst_cnt", 0, 0, 0, 0, P0, 0, 1, P0, 95));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the 4-wide rename stage.
- Supplies new preg indices to the RAT write port (added_preg_index_vec) for each renamed instruction that writes a non-zero rd.
- Takes back superseded pregs (the RAT's rd_history_preg values, carried through the ROB) at commit.
- Restores its speculative allocation pointer on recover, in the same cycle the RAT restores its table.

Parameters:
- NUM_PREG, 128, total physical registers; PREG_W = `PREG_INDEX_WIDTH (7).
- NUM_AREG, 32, architectural registers; pregs 0..31 are owned by the RAT after reset.
- WAYS, 4, rename and commit width.
- DEPTH, NUM_PREG-NUM_AREG = 96, derived localparam; circular-buffer entries.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_req_vec  in  WAYS  lane i needs a new preg (rd exists and rd != 0).
- alloc_en  in  1  rename stage advances this cycle.
- alloc_ready  out  1  free_count >= popcount(alloc_req_vec); combinational.
- alloc_preg_vec  out  [WAYS][PREG_W]  preg for each requesting lane; 0 for non-requesting lanes; combinational.
- commit_valid_vec  in  WAYS  committed lanes that allocated a preg.
- commit_free_preg_vec  in  [WAYS][PREG_W]  old (history) preg released by each committed lane.
- recover_valid  in  1  flush; discard all speculative allocations.
- free_count  out  7  number of free entries, 0..96.

Behaviour:
- Storage:
  - fl[DEPTH] of PREG_W bits.
  - Registers: head (speculative), arch_head (committed), tail; each in 0..DEPTH-1, wrapping modulo DEPTH (95+1 -> 0; not a power of two, wrap is explicit).
  - count register, 7 bits.
- Reset (rst=1 at posedge):
  - fl[k] = 32+k.
  - head = arch_head = tail = 0, count = 96.
  - Outputs follow: alloc_ready = 1 when no request is pending; free_count = 96.
  - Reset has priority over everything, including mid-operation.
- Allocation:
  - Lane i reads fl[(head + popcount(alloc_req_vec[i-1:0])) mod DEPTH], compacted in lane order.
  - fire = alloc_en & alloc_ready & !recover_valid.
  - On fire: head += n_alloc = popcount(alloc_req_vec).
  - Allocation is all-or-nothing; no partial grant.
  - alloc_req_vec = 0 is always ready and changes nothing.
- Free (commit):
  - n_free = popcount(commit_valid_vec).
  - Valid lanes are compacted: fl[(tail + prefix) mod DEPTH] <= commit_free_preg_vec[i]; tail += n_free.
  - arch_head += n_free, because each committed lane consumed exactly one allocated entry.
  - Commit is applied even when recover_valid = 1.
- Count, normal cycle: count_next = count - (fire ? n_alloc : 0) + n_free.
  - Entries freed this cycle are not allocatable until the next cycle; alloc_ready uses the current count.
- Recover:
  - head <= arch_head + n_free (mod DEPTH); count <= DEPTH.
  - Invariant: the architectural free count is always DEPTH, because commit frees and consumes in equal numbers.
  - No allocation occurs in a recover cycle.
- Latency: alloc_preg_vec is valid in the request cycle; pointer and count updates are visible the next cycle.
- Preconditions (checked by assertions, not by RTL logic):
  - count + n_free <= DEPTH.
  - commit_free_preg_vec[i] != 0 for valid lanes.
  - commit_valid_vec lanes never exceed the outstanding allocations.

Decomposition:
- Shared package (defs.sv): NUM_PREG, NUM_AREG, WAYS, PREG_W, and a preg_idx_t typedef.
- One natural sub-module, fl_compact: prefix-popcount lane offset generator. It is used twice, once for the allocation read and once for the commit write.

Test Plan:
- Post-reset, alloc_req_vec=1111, alloc_en=1 -> alloc_preg_vec = {35,34,33,32} (lane3..lane0); next cycle free_count = 92.
- Sparse request, alloc_req_vec=1010 after reset -> lane1=32, lane3=33, lanes 0 and 2 = 0; next cycle free_count = 94.
- Starvation:
  - Drain to free_count = 2, then alloc_req_vec=0111 -> alloc_ready = 0; head and count unchanged.
  - Then alloc_req_vec=0011 -> grants both entries; free_count = 0.
- Wrap-around:
  - Allocate 96 entries, then commit and free pregs 5, 6, 7, 8 at tail 0..3.
  - Allocate 4 -> returns 5, 6, 7, 8; head wraps from 95 to 0.
  - Then a simultaneous alloc 2 + free 2 -> free_count unchanged.
- Recover:
  - Allocate 8 (pregs 32..39).
  - Same cycle: commit 2 lanes freeing pregs 3 and 4, with recover_valid=1.
  - Next cycle: free_count = 96, head = 2, next allocation returns 34, fl[0..1] = {3,4}.
- Reset mid-stream: rst=1 while alloc_en=1 with allocations and frees outstanding -> next cycle free_count = 96, and alloc_req_vec=0001 returns 32.
